// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between c_n requesters.
// One transaction at a time; the winner gets done/err/rdata when the bus cycle ends.
module i2c_bus_arbiter #(
  parameter int c_n            = 2,
  parameter int c_timeout_bits = 20
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [c_n-1:0]       req,
  input  logic [32*c_n-1:0]    cmd,
  output logic [c_n-1:0]       grant,
  output logic [c_n-1:0]       done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 m_wr_ctrl,
  output logic [31:0]          m_ctrl_data,
  input  logic [31:0]          m_status,
  output logic [2:0]           o_dbg_state
);

  localparam int c_iw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_n-1:0]            c_one     = 1;
  localparam logic [c_timeout_bits-1:0] c_cnt_one = 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  state_t                    r_state, w_next;
  logic [c_n-1:0]            r_grant, w_grant_n;
  logic [c_n-1:0]            r_done, w_done_n;
  logic                      r_err, w_err_n;
  logic [7:0]                r_rdata, w_rdata_n;
  logic                      r_wr, w_wr_n;
  logic [31:0]               r_data, w_data_n;
  logic [c_iw-1:0]           r_last, w_last_n;
  logic [c_iw-1:0]           r_winner, w_winner_n;
  logic [c_timeout_bits-1:0] r_cnt, w_cnt_n;
  logic                      w_cnt_max;
  logic                      w_busy;
  logic                      w_any;
  logic [c_iw-1:0]           w_pick;
  logic                      w_unused;

  assign w_busy    = m_status[31];
  assign w_cnt_max = &r_cnt;
  assign w_unused  = ^{m_status[30:29], m_status[27:8]};

  // First requester at or after last+1, wrapping, so the previous winner goes last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= c_n; k++) begin
      if (!w_any && req[(int'(r_last) + k) % c_n]) begin
        w_any  = 1'b1;
        w_pick = c_iw'((int'(r_last) + k) % c_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_last   <= c_iw'(c_n - 1);
      r_winner <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_grant  <= w_grant_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_rdata  <= w_rdata_n;
      r_wr     <= w_wr_n;
      r_data   <= w_data_n;
      r_last   <= w_last_n;
      r_winner <= w_winner_n;
      r_cnt    <= w_cnt_n;
    end
  end

  // Busy is checked before the timeout so a start on the last counted cycle still wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_any) w_next = S_ISSUE;
      S_ISSUE:      w_next = S_WAIT_START;
      S_WAIT_START: if (w_busy) w_next = S_WAIT_END;
                    else if (w_cnt_max) w_next = S_FINISH;
      S_WAIT_END:   if (!w_busy || w_cnt_max) w_next = S_FINISH;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_n  = r_grant;
    w_done_n   = '0;
    w_err_n    = r_err;
    w_rdata_n  = r_rdata;
    w_wr_n     = 1'b0;
    w_data_n   = r_data;
    w_last_n   = r_last;
    w_winner_n = r_winner;
    w_cnt_n    = w_cnt_max ? r_cnt : r_cnt + c_cnt_one;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_winner_n = w_pick;
          w_grant_n  = c_one << w_pick;
          w_data_n   = cmd[32*int'(w_pick) +: 32];
        end
      end
      S_ISSUE: begin
        w_wr_n  = 1'b1;
        w_err_n = 1'b0;
        w_cnt_n = '0;
      end
      S_WAIT_START: begin
        if (w_busy) w_cnt_n = '0;
        else if (w_cnt_max) w_err_n = 1'b1;
      end
      S_WAIT_END: begin
        if (!w_busy) begin
          w_rdata_n = m_status[7:0];
          w_err_n   = ~m_status[28];
        end else if (w_cnt_max) begin
          w_err_n = 1'b1;
        end
      end
      S_FINISH: begin
        w_done_n  = c_one << r_winner;
        w_grant_n = '0;
        w_last_n  = r_winner;
      end
      default: ;
    endcase
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign err         = r_err;
  assign rdata       = r_rdata;
  assign m_wr_ctrl   = r_wr;
  assign m_ctrl_data = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a behavioural i2c_master status model.
// The timeout is shrunk to 16 cycles, so the normal bus cycles stay shorter than that.
module tb_i2c_bus_arbiter;

  localparam int c_n  = 2;
  localparam int c_tb = 4;

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_wstart = 3'd2;
  localparam logic [2:0] st_wend  = 3'd3;
  localparam logic [2:0] st_fin   = 3'd4;

  logic              clk;
  logic              resetn;
  logic [c_n-1:0]    req;
  logic [32*c_n-1:0] cmd;
  logic [c_n-1:0]    grant;
  logic [c_n-1:0]    done;
  logic              err;
  logic [7:0]        rdata;
  logic              m_wr_ctrl;
  logic [31:0]       m_ctrl_data;
  logic [31:0]       m_status = '0;
  logic [2:0]        dbg_state;

  int   n_pass  = 0;
  int   n_total = 0;

  int   mdl_delay = 3;
  int   mdl_len   = 10;
  logic mdl_ready = 1'b1;
  logic [7:0] mdl_data = 8'h59;
  logic mdl_never = 1'b0;

  i2c_bus_arbiter #(.c_n(c_n), .c_timeout_bits(c_tb)) u_dut (
    .clk(clk), .resetn(resetn), .req(req), .cmd(cmd), .grant(grant), .done(done),
    .err(err), .rdata(rdata), .m_wr_ctrl(m_wr_ctrl), .m_ctrl_data(m_ctrl_data),
    .m_status(m_status), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // i2c_master model: busy rises mdl_delay cycles after the strobe, lasts mdl_len cycles
  always begin
    @(negedge clk);
    if (m_wr_ctrl === 1'b1 && !mdl_never) begin
      repeat (mdl_delay) @(posedge clk);
      #1 m_status = 32'h8000_0000;
      repeat (mdl_len) @(posedge clk);
      #1 m_status = {3'b000, mdl_ready, 20'h0, mdl_data};
    end
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_g, input logic [31:0] exp_d);
    int k = 0;
    while (grant === '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, " grant_seen"}, 32'(k < 100), 32'd1);
    check({tag, " grant"}, 32'(grant), 32'(exp_g));
    check({tag, " m_ctrl_data"}, m_ctrl_data, exp_d);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_dn, input logic exp_e,
                           input logic [7:0] exp_rd, input logic [1:0] req_after);
    int k = 0;
    while (done === '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done_seen"}, 32'(k < 200), 32'd1);
    check({tag, " done"}, 32'(done), 32'(exp_dn));
    check({tag, " err"}, 32'(err), 32'(exp_e));
    check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
    req = req_after;
    @(negedge clk);
    check({tag, " done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic saw_done;

    resetn = 1'b0;
    req    = '0;
    cmd    = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("rst grant", 32'(grant), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst wr", 32'(m_wr_ctrl), 32'd0);
    check("rst data", m_ctrl_data, 32'd0);
    check("rst state", 32'(dbg_state), 32'(st_idle));

    // single read from requester 0: latency and completion path
    cmd[31:0] = 32'h806F_0000;
    req = 2'b01;
    @(negedge clk);
    check("t1 grant", 32'(grant), 32'h1);
    check("t1 wr_early", 32'(m_wr_ctrl), 32'd0);
    check("t1 data", m_ctrl_data, 32'h806F_0000);
    @(negedge clk);
    check("t1 wr_pulse", 32'(m_wr_ctrl), 32'd1);
    check("t1 state_ws", 32'(dbg_state), 32'(st_wstart));
    @(negedge clk);
    check("t1 wr_single", 32'(m_wr_ctrl), 32'd0);
    n = 0;
    while (m_status[31] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (m_status[31] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("t1 busy_cycle", 32'(n < 100), 32'd1);
    check("t1 done_at_fall", 32'(done), 32'd0);
    @(negedge clk);
    check("t1 state_fin", 32'(dbg_state), 32'(st_fin));
    check("t1 done_fin", 32'(done), 32'd0);
    @(negedge clk);
    check("t1 done", 32'(done), 32'h1);
    check("t1 err", 32'(err), 32'd0);
    check("t1 rdata", 32'(rdata), 32'h59);
    req = 2'b00;
    @(negedge clk);
    check("t1 done_single", 32'(done), 32'd0);

    // master never answers: WAIT_START lasts 2^4 cycles, then err with rdata kept
    mdl_never = 1'b1;
    cmd[63:32] = 32'h006F_0620;
    req = 2'b10;
    n = 0;
    while (dbg_state !== st_wstart && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (dbg_state === st_wstart && n < 100) begin @(negedge clk); n++; end
    check("t3 wait_cycles", 32'(n), 32'd16);
    check("t3 state_fin", 32'(dbg_state), 32'(st_fin));
    @(negedge clk);
    check("t3 done", 32'(done), 32'h2);
    check("t3 err", 32'(err), 32'd1);
    check("t3 rdata", 32'(rdata), 32'h59);
    req = 2'b00;
    mdl_never = 1'b0;
    @(negedge clk);
    check("t3 done_single", 32'(done), 32'd0);

    // NACK completion still captures read data
    mdl_ready = 1'b0;
    mdl_data  = 8'hAA;
    req = 2'b10;
    wait_done("t4", 2'b10, 1'b1, 8'hAA, 2'b00);

    // both requesters held high: strict alternation starting at 0
    mdl_ready = 1'b1;
    mdl_data  = 8'h3C;
    cmd[31:0]  = 32'h806F_0300;
    cmd[63:32] = 32'h006F_0620;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        wait_grant("t2 r0", 2'b01, 32'h806F_0300);
        wait_done("t2 r0", 2'b01, 1'b0, 8'h3C, (i == 3) ? 2'b00 : 2'b11);
      end else begin
        wait_grant("t2 r1", 2'b10, 32'h006F_0620);
        wait_done("t2 r1", 2'b10, 1'b0, 8'h3C, (i == 3) ? 2'b00 : 2'b11);
      end
    end

    // reset during WAIT_END: no done, pointer back to requester 0
    req = 2'b10;
    n = 0;
    while (dbg_state !== st_wend && n < 50) begin @(negedge clk); n++; end
    check("t5 reached_wend", 32'(dbg_state), 32'(st_wend));
    resetn = 1'b0;
    req = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    check("t5 grant_rst", 32'(grant), 32'd0);
    check("t5 state_rst", 32'(dbg_state), 32'(st_idle));
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== '0 || grant !== '0) saw_done = 1'b1;
    end
    check("t5 no_done", 32'(saw_done), 32'd0);
    check("t5 busy_fell", 32'(m_status[31]), 32'd0);
    req = 2'b11;
    @(negedge clk);
    check("t5 grant_r0", 32'(grant), 32'h1);
    wait_done("t5", 2'b01, 1'b0, 8'h3C, 2'b00);

    // drop req and change cmd after the grant: latched word and done survive
    cmd[31:0] = 32'h006F_0712;
    req = 2'b01;
    wait_grant("t6", 2'b01, 32'h006F_0712);
    req = 2'b00;
    cmd[31:0] = 32'h1234_5678;
    @(negedge clk);
    check("t6 data_kept", m_ctrl_data, 32'h006F_0712);
    check("t6 grant_kept", 32'(grant), 32'h1);
    wait_done("t6", 2'b01, 1'b0, 8'h3C, 2'b00);
    check("t6 grant_clr", 32'(grant), 32'd0);
    check("t6 state_idle", 32'(dbg_state), 32'(st_idle));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
